// File: rtl/rob_multi_commit.sv
// Circular reorder buffer: one allocation per cycle, NUM_WB writeback ports,
// up to COMMIT_W in-order retirements per cycle and selective squash of younger entries.
module rob_multi_commit #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned PAYLOAD_W = 64,
    parameter int unsigned RESULT_W  = 16,
    parameter int unsigned NUM_WB    = 3,
    parameter int unsigned COMMIT_W  = 2,
    parameter int unsigned TAG_W     = $clog2(DEPTH)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          alloc_valid_i,
    input  logic [PAYLOAD_W-1:0]          alloc_payload_i,
    output logic                          alloc_ready_o,
    output logic [TAG_W-1:0]              alloc_tag_o,
    input  logic [NUM_WB-1:0]             wb_valid_i,
    input  logic [NUM_WB*TAG_W-1:0]       wb_tag_i,
    input  logic [NUM_WB*RESULT_W-1:0]    wb_data_i,
    output logic [COMMIT_W-1:0]           commit_valid_o,
    output logic [COMMIT_W*PAYLOAD_W-1:0] commit_payload_o,
    output logic [COMMIT_W*RESULT_W-1:0]  commit_data_o,
    input  logic                          commit_ready_i,
    input  logic                          flush_i,
    input  logic [TAG_W-1:0]              flush_tag_i,
    output logic [TAG_W:0]                count_o,
    output logic                          empty_o,
    output logic                          full_o
);

    localparam int unsigned CNT_W = TAG_W + 1;

    logic [TAG_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [DEPTH-1:0]     occ_q, occ_d, done_q, done_d;
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [PAYLOAD_W-1:0] payload_d [DEPTH];
    logic [RESULT_W-1:0]  data_q [DEPTH];
    logic [RESULT_W-1:0]  data_d [DEPTH];

    logic [TAG_W-1:0]     age_c [DEPTH];
    logic [DEPTH-1:0]     live_c;
    logic [TAG_W-1:0]     flush_age_c;
    logic                 flush_live_c;
    logic                 alloc_fire_c;
    logic [CNT_W-1:0]     n_commit_c;

    assign count_o       = count_q;
    assign empty_o       = (count_q == '0);
    assign full_o        = (count_q == CNT_W'(DEPTH));
    assign alloc_ready_o = ~full_o & ~flush_i;
    assign alloc_tag_o   = tail_q;
    assign alloc_fire_c  = alloc_valid_i & alloc_ready_o;
    assign flush_age_c   = flush_tag_i - head_q;
    assign flush_live_c  = flush_i & ({1'b0, flush_age_c} < count_q);

    // Age of every slot relative to head; live means inside the occupied window.
    always_comb begin : live_calc
        for (int unsigned t = 0; t < DEPTH; t++) begin
            age_c[t]  = TAG_W'(t) - head_q;
            live_c[t] = occ_q[t] & ({1'b0, age_c[t]} < count_q);
        end
    end

    // Retirable slots form a contiguous done prefix starting at head.
    always_comb begin : commit_calc
        logic prefix;
        prefix           = 1'b1;
        commit_valid_o   = '0;
        commit_payload_o = '0;
        commit_data_o    = '0;
        for (int unsigned k = 0; k < COMMIT_W; k++) begin
            prefix = prefix & (CNT_W'(k) < count_q) & done_q[head_q + TAG_W'(k)];
            commit_valid_o[k]                         = prefix;
            commit_payload_o[k*PAYLOAD_W +: PAYLOAD_W] = payload_q[head_q + TAG_W'(k)];
            commit_data_o[k*RESULT_W +: RESULT_W]      = data_q[head_q + TAG_W'(k)];
        end
    end

    always_comb begin : n_commit_calc
        n_commit_c = '0;
        if (commit_ready_i) begin
            for (int unsigned k = 0; k < COMMIT_W; k++) begin
                n_commit_c = n_commit_c + CNT_W'(commit_valid_o[k]);
            end
        end
    end

    always_comb begin : next_state
        head_d    = head_q + TAG_W'(n_commit_c);
        tail_d    = tail_q;
        count_d   = count_q;
        occ_d     = occ_q;
        done_d    = done_q;
        payload_d = payload_q;
        data_d    = data_q;

        // Highest port applied first so the lowest index overrides on a tag collision.
        for (int unsigned t = 0; t < DEPTH; t++) begin
            for (int p = int'(NUM_WB) - 1; p >= 0; p--) begin
                if (wb_valid_i[p] && (wb_tag_i[p*int'(TAG_W) +: TAG_W] == TAG_W'(t))
                    && live_c[t] && !done_q[t]) begin
                    done_d[t] = 1'b1;
                    data_d[t] = wb_data_i[p*int'(RESULT_W) +: RESULT_W];
                end
            end
        end

        for (int unsigned k = 0; k < COMMIT_W; k++) begin
            if (commit_ready_i && commit_valid_o[k]) begin
                occ_d[head_q + TAG_W'(k)]  = 1'b0;
                done_d[head_q + TAG_W'(k)] = 1'b0;
            end
        end

        if (flush_live_c) begin
            for (int unsigned t = 0; t < DEPTH; t++) begin
                if (age_c[t] > flush_age_c) begin
                    occ_d[t]  = 1'b0;
                    done_d[t] = 1'b0;
                end
            end
            // Retiring past the flush target leaves the buffer empty.
            if (n_commit_c > {1'b0, flush_age_c}) begin
                count_d = '0;
            end else begin
                count_d = {1'b0, flush_age_c} + CNT_W'(1) - n_commit_c;
            end
            tail_d = head_d + TAG_W'(count_d);
        end else begin
            count_d = count_q + CNT_W'(alloc_fire_c) - n_commit_c;
            tail_d  = tail_q + TAG_W'(alloc_fire_c);
        end

        if (alloc_fire_c) begin
            payload_d[tail_q] = alloc_payload_i;
            occ_d[tail_q]     = 1'b1;
            done_d[tail_q]    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            occ_q   <= '0;
            done_q  <= '0;
            for (int unsigned t = 0; t < DEPTH; t++) begin
                payload_q[t] <= '0;
                data_q[t]    <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            occ_q     <= occ_d;
            done_q    <= done_d;
            payload_q <= payload_d;
            data_q    <= data_d;
        end
    end

endmodule
